// File: rtl/halfword_packer.sv
// Narrows 32-bit words to 16 bits (signed/unsigned fit check) and packs pairs into 32-bit words.
// Latency: packed word valid the edge the second halfword (or a flush) is accepted.
// Backpressure: in_ready drops only while a packed word waits and out_ready is low.
module halfword_packer #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             signOrZero,
  input  logic             flush,
  input  logic             clr_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_err,
  output logic             out_partial,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] word_count
);

  typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;

  typedef struct packed {
    logic        err;
    logic [15:0] hw;
  } half_t;

  state_t      state_q, state_d;
  half_t       held_q, held_d;
  half_t       in_half;
  logic [31:0] out_data_d;
  logic        out_err_d;
  logic        out_partial_d;
  logic        accept;
  logic        pop;
  logic        fit_err;

  // Signed fit: upper half must replicate bit 15; unsigned fit: upper half must be zero.
  assign fit_err  = signOrZero ? (in_data[31:16] != {16{in_data[15]}})
                               : (in_data[31:16] != 16'h0000);
  assign in_half  = '{err: fit_err, hw: in_data[15:0]};

  assign in_ready  = (state_q != FULL) | out_ready;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == FULL);
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d       = state_q;
    held_d        = held_q;
    out_data_d    = out_data;
    out_err_d     = out_err;
    out_partial_d = out_partial;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = HALF;
          held_d  = in_half;
        end
      end
      HALF: begin
        if (accept) begin
          state_d       = FULL;
          out_data_d    = {in_half.hw, held_q.hw};
          out_err_d     = held_q.err | in_half.err;
          out_partial_d = 1'b0;
          held_d        = '0;
        end else if (flush) begin
          state_d       = FULL;
          out_data_d    = {16'h0000, held_q.hw};
          out_err_d     = held_q.err;
          out_partial_d = 1'b1;
          held_d        = '0;
        end
      end
      FULL: begin
        // Pop and refill can happen on the same edge, so the pipe never bubbles.
        if (out_ready) begin
          if (accept) begin
            state_d = HALF;
            held_d  = in_half;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= EMPTY;
      held_q      <= '0;
      out_data    <= '0;
      out_err     <= 1'b0;
      out_partial <= 1'b0;
    end else begin
      state_q     <= state_d;
      held_q      <= held_d;
      out_data    <= out_data_d;
      out_err     <= out_err_d;
      out_partial <= out_partial_d;
    end
  end

  // A failing accept outranks a concurrent clear.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ovf_sticky <= 1'b0;
    end else if (accept & fit_err) begin
      ovf_sticky <= 1'b1;
    end else if (clr_ovf) begin
      ovf_sticky <= 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      word_count <= '0;
    end else if (pop) begin
      word_count <= word_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/halfword_packer.md
# halfword_packer

Narrowing and packing stage, the inverse of the datapath's 16→32 sign/zero extension. Accepts 32-bit words, checks that each value survives truncation to 16 bits under signed or unsigned interpretation, truncates it, and packs consecutive halfwords two per 32-bit output word for halfword-array stores. It sits between the execute-stage result stream and the store buffer, with valid/ready handshakes on both sides.

## Interface
- CNT_W, 16, width of the packed-word counter.
- Clk  input  1  clock; all state updates on rising edge.
- Rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is presented.
- in_ready  output  1  block can accept in_data this cycle.
- in_data  input  32  word to narrow.
- signOrZero  input  1  fit rule: 1 = signed, 0 = unsigned. Sampled with each accepted word.
- flush  input  1  emit a pending lone halfword as a partial word.
- clr_ovf  input  1  synchronous clear of ovf_sticky.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer takes out_data this cycle.
- out_data  output  32  packed word: {second halfword, first halfword}.
- out_err  output  1  at least one halfword in out_data failed the fit check.
- out_partial  output  1  only out_data[15:0] is meaningful; [31:16] = 0.
- ovf_sticky  output  1  set by any accepted fit failure.
- word_count  output  CNT_W  number of packed words delivered; wraps modulo 2^CNT_W.

## Operation
- **Fit check, per accepted word:**
  - signed: pass iff in_data[31:16] == {16{in_data[15]}}.
  - unsigned: pass iff in_data[31:16] == 0.
  - The truncated halfword is always in_data[15:0], whether or not the check passes.
- **States:** EMPTY, HALF (low halfword and its error bit held), FULL (output register valid).
- **Acceptance and in_ready:**
  - accept = in_valid & in_ready.
  - in_ready = (state != FULL) | out_ready. It is combinational from state and out_ready.
- **Transitions:**
  - EMPTY + accept → HALF. Store the halfword and its error bit.
  - HALF + accept → FULL. out_data = {new, held}; out_err = OR of both error bits; out_partial = 0.
  - HALF + flush, no accept → FULL. out_data = {16'h0000, held}; out_err = held error bit; out_partial = 1.
  - HALF + flush + accept → the accept wins and the pair is formed; flush is ignored that cycle.
  - FULL + out_ready, no accept → EMPTY.
  - FULL + out_ready + accept → HALF. The output pops and the new halfword becomes the held low half in the same edge.
  - FULL + !out_ready → hold. out_data, out_err and out_partial are stable.
- **Flush** has no effect in EMPTY or FULL.
- **word_count** increments on every out_valid & out_ready cycle, partial words included. It wraps from 2^CNT_W−1 to 0.
- **ovf_sticky:**
  - set on any accept whose fit check fails.
  - clr_ovf clears it.
  - A failing accept in the same cycle as clr_ovf leaves it set (set wins).
- out_valid = (state == FULL).

## Timing
- Reset (Rst low, asynchronous) forces: state EMPTY, out_valid 0, out_data 0, out_err 0, out_partial 0, ovf_sticky 0, word_count 0, held halfword cleared. in_ready reads 1 while out_ready is don't-care.
- Reset mid-operation discards any held halfword and any undelivered output word; nothing is emitted after reset release.
- **Latency:**
  - A second halfword accepted at edge N gives out_valid = 1 from edge N through the edge at which out_ready is high.
  - A flush at edge N gives the partial word valid from edge N.
- **Throughput:** one input word per cycle sustained while out_ready = 1, giving one packed word every two cycles.
- in_data, signOrZero and flush must be stable before the clock edge; they have no combinational path to any output except through in_ready's dependence on out_ready.

## Test plan
- **Signed pair:** signOrZero = 1; accept 0xFFFF8001, then 0x00001234 → out_data = 0x12348001, out_err = 0, out_partial = 0, word_count 0 → 1 after out_ready handshake.
- **Signed overflow:** accept 0x00018000 then 0x00000001 with signOrZero = 1 → out_data = 0x00018000, out_err = 1, ovf_sticky = 1. Assert clr_ovf one cycle → ovf_sticky = 0.
- **Unsigned rule:** signOrZero = 0; accept 0x0000FFFF then 0xFFFFFFFF → out_data = 0xFFFFFFFF, out_err = 1. Repeat with 0x0000FFFF twice → out_err = 0.
- **Backpressure:**
  - Reach FULL with out_ready = 0 → in_ready = 0 and out_data held for 5 cycles.
  - Then drive out_ready = 1 with in_valid = 1, in_data = 0x00000007 → output pops, state HALF, held low half = 0x0007.
- **Flush:**
  - In HALF holding 0x0000ABCD (unsigned), pulse flush → out_data = 0x0000ABCD, out_partial = 1.
  - Flush with a simultaneous accept → a full pair is formed, out_partial = 0.
- **Reset and wrap:**
  - Assert Rst low while in HALF → all outputs 0, in_ready = 1, and the next pair is packed from scratch.
  - With CNT_W = 2, deliver 5 words → word_count = 1.
